// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results directly and waits for, extracts and retires load data.
// Latency: 1 cycle for ALU results; for loads, 1 cycle after mem_rvalid, or an err pulse on timeout.
// Backpressure: ex_ready drops while a load is outstanding, so upstream stalls until the load retires.
module wb_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rd_we,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        load_pending,
  output logic [4:0]  pend_rd,
  output logic        err
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [4:0]  cap_rd, cap_rd_nxt;
  logic [2:0]  cap_f3, cap_f3_nxt;
  logic [1:0]  cap_lo, cap_lo_nxt;
  logic        rd_we_nxt, err_nxt;
  logic [4:0]  wreg_nxt;
  logic [31:0] wdata_nxt;
  logic        load_legal;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_value;

  assign ex_ready     = (state == IDLE);
  assign load_pending = (state == WAIT_LOAD);
  assign pend_rd      = (state == WAIT_LOAD) ? cap_rd : 5'd0;

  // Reserved funct3 codes and misaligned halfword/word accesses are rejected at acceptance.
  always_comb begin
    load_legal = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~ex_addr_lo[0];
      3'b010:         load_legal = (ex_addr_lo == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  end

  always_comb begin
    ld_byte  = mem_rdata[{cap_lo, 3'b000} +: 8];
    ld_half  = mem_rdata[{cap_lo[1], 4'b0000} +: 16];
    ld_value = mem_rdata;
    case (cap_f3)
      3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_value = {24'd0, ld_byte};
      3'b101:  ld_value = {16'd0, ld_half};
      default: ld_value = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    cap_rd_nxt = cap_rd;
    cap_f3_nxt = cap_f3;
    cap_lo_nxt = cap_lo;
    rd_we_nxt  = 1'b0;
    err_nxt    = 1'b0;
    wreg_nxt   = writeReg;
    wdata_nxt  = writeData;
    case (state)
      IDLE: begin
        if (ex_valid) begin
          if (!ex_is_load) begin
            rd_we_nxt = (ex_rd != 5'd0);
            wreg_nxt  = ex_rd;
            wdata_nxt = ex_result;
          end else if (load_legal) begin
            cap_rd_nxt = ex_rd;
            cap_f3_nxt = ex_funct3;
            cap_lo_nxt = ex_addr_lo;
            cnt_nxt    = 8'd0;
            state_nxt  = WAIT_LOAD;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        // Data arriving on the expiry cycle still wins over the timeout.
        if (mem_rvalid) begin
          rd_we_nxt = (cap_rd != 5'd0);
          wreg_nxt  = cap_rd;
          wdata_nxt = ld_value;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          err_nxt   = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      cap_rd    <= 5'd0;
      cap_f3    <= 3'd0;
      cap_lo    <= 2'd0;
      rd_we     <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cap_rd    <= cap_rd_nxt;
      cap_f3    <= cap_f3_nxt;
      cap_lo    <= cap_lo_nxt;
      rd_we     <= rd_we_nxt;
      writeReg  <= wreg_nxt;
      writeData <= wdata_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic against a countdown-based reference model.
module tb_wb_stage;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_is_load = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_result = '0;
  logic [2:0]  ex_funct3 = '0;
  logic [1:0]  ex_addr_lo = '0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        ex_ready, rd_we, load_pending, err;
  logic [4:0]  writeReg, pend_rd;
  logic [31:0] writeData;

  int errors = 0;
  int checks = 0;

  wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rd_we(rd_we), .writeReg(writeReg),
    .writeData(writeData), .load_pending(load_pending), .pend_rd(pend_rd), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_is_load = 1'b0; mem_rvalid = 1'b0;
  endtask

  task automatic issue_load(input logic [2:0] f3, input logic [1:0] lo, input logic [4:0] rd);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = f3; ex_addr_lo = lo; ex_rd = rd;
  endtask

  task automatic issue_alu(input logic [4:0] rd, input logic [31:0] res);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = rd; ex_result = res;
  endtask

  // Architectural meaning of a load: pick byte/half by address, then sign or zero extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * lo)) & 32'hFF;
    h = (w >> (16 * (lo / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [2:0] f3, input logic [1:0] lo);
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b1;
    if (f3 == 3'd1 || f3 == 3'd5) return (lo % 2) == 0;
    if (f3 == 3'd2) return lo == 2'd0;
    return 1'b0;
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL reset_rd_we got=%0b exp=0", rd_we); end
    checks++; if (writeReg !== 5'd0) begin errors++; $display("FAIL reset_writeReg got=%0d exp=0", writeReg); end
    checks++; if (writeData !== 32'd0) begin errors++; $display("FAIL reset_writeData got=%h exp=0", writeData); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    checks++; if (load_pending !== 1'b0 || pend_rd !== 5'd0) begin errors++; $display("FAIL reset_pending got=%0b/%0d exp=0/0", load_pending, pend_rd); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ex_ready); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    issue_alu(5'd5, 32'hDEAD_BEEF);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL alu_ready got=%0b exp=1", ex_ready); end
    tick(); idle_inputs();
    checks++; if (rd_we !== 1'b1) begin errors++; $display("FAIL alu_rd_we got=%0b exp=1", rd_we); end
    checks++; if (writeReg !== 5'd5) begin errors++; $display("FAIL alu_writeReg got=%0d exp=5", writeReg); end
    checks++; if (writeData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_writeData got=%h exp=deadbeef", writeData); end
    tick();
    checks++; if (rd_we !== 1'b0) begin errors++; $display("FAIL alu_we_pulse got=%0b exp=0", rd_we); end
  endtask

  task automatic test_lb();
    issue_load(3'b000, 2'b11, 5'd7);
    tick(); idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL lb_wait_ready cyc=%0d got=%0b exp=0", i, ex_ready); end
      checks++; if (load_pending !== 1'b1 || pend_rd !== 5'd7) begin errors++; $display("FAIL lb_wait_pend cyc=%0d got=%0b/%0d exp=1/7", i, load_pending, pend_rd); end
      checks++; if (rd_we !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL lb_wait_quiet cyc=%0d we=%0b err=%0b exp=0/0", i, rd_we, err); end
      tick();
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    tick(); mem_rvalid = 1'b0;
    checks++; if (rd_we !== 1'b1 || writeReg !== 5'd7) begin errors++; $display("FAIL lb_write got we=%0b reg=%0d exp=1/7", rd_we, writeReg); end
    checks++; if (writeData !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got=%h exp=ffffff80", writeData); end
    checks++; if (ex_ready !== 1'b1 || load_pending !== 1'b0 || pend_rd !== 5'd0) begin errors++; $display("FAIL lb_done got rdy=%0b pend=%0b/%0d exp=1/0/0", ex_ready, load_pending, pend_rd); end
  endtask

  task automatic test_lhu_misalign();
    issue_load(3'b101, 2'b10, 5'd9);
    tick(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
    tick(); mem_rvalid = 1'b0;
    checks++; if (rd_we !== 1'b1 || writeData !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got we=%0b data=%h exp=1/0000beef", rd_we, writeData); end
    issue_load(3'b001, 2'b01, 5'd3);
    tick(); idle_inputs();
    checks++; if (err !== 1'b1 || rd_we !== 1'b0) begin errors++; $display("FAIL lh_misalign got err=%0b we=%0b exp=1/0", err, rd_we); end
    checks++; if (ex_ready !== 1'b1 || load_pending !== 1'b0) begin errors++; $display("FAIL lh_misalign_idle got rdy=%0b pend=%0b exp=1/0", ex_ready, load_pending); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL lh_err_pulse got=%0b exp=0", err); end
  endtask

  task automatic test_timeout();
    issue_load(3'b010, 2'b00, 5'd10);
    tick(); idle_inputs();
    for (int i = 1; i < TO; i++) begin
      tick();
      checks++; if (err !== 1'b0 || ex_ready !== 1'b0) begin errors++; $display("FAIL to_early cyc=%0d err=%0b rdy=%0b exp=0/0", i, err, ex_ready); end
    end
    tick();
    checks++; if (err !== 1'b1 || rd_we !== 1'b0) begin errors++; $display("FAIL to_expire got err=%0b we=%0b exp=1/0", err, rd_we); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL to_ready got=%0b exp=1", ex_ready); end
    issue_load(3'b010, 2'b00, 5'd10);
    tick(); idle_inputs();
    for (int i = 1; i < TO; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick(); mem_rvalid = 1'b0;
    checks++; if (err !== 1'b0 || rd_we !== 1'b1) begin errors++; $display("FAIL to_race got err=%0b we=%0b exp=0/1", err, rd_we); end
    checks++; if (writeReg !== 5'd10 || writeData !== 32'h1234_5678) begin errors++; $display("FAIL to_race_data got %0d/%h exp=10/12345678", writeReg, writeData); end
  endtask

  task automatic test_rd0();
    issue_alu(5'd0, 32'h0000_0055);
    tick(); idle_inputs();
    checks++; if (rd_we !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'h55) begin errors++; $display("FAIL rd0_alu got we=%0b %0d/%h exp=0 0/55", rd_we, writeReg, writeData); end
    issue_load(3'b010, 2'b00, 5'd0);
    tick(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick(); mem_rvalid = 1'b0;
    checks++; if (rd_we !== 1'b0 || err !== 1'b0 || writeData !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd0_lw got we=%0b err=%0b data=%h exp=0/0/cafef00d", rd_we, err, writeData); end
  endtask

  task automatic test_back_to_back();
    issue_load(3'b100, 2'b01, 5'd4);
    tick(); idle_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_A500;
    tick(); mem_rvalid = 1'b0;
    checks++; if (rd_we !== 1'b1 || writeData !== 32'h0000_00A5) begin errors++; $display("FAIL b2b_lbu got we=%0b data=%h exp=1/000000a5", rd_we, writeData); end
    issue_alu(5'd6, 32'h0BAD_CAFE);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b exp=1", ex_ready); end
    tick(); idle_inputs();
    checks++; if (rd_we !== 1'b1 || writeReg !== 5'd6 || writeData !== 32'h0BAD_CAFE) begin errors++; $display("FAIL b2b_alu got we=%0b %0d/%h exp=1 6/0badcafe", rd_we, writeReg, writeData); end
  endtask

  task automatic test_reset_wait();
    issue_alu(5'd17, 32'hAAAA_5555);
    tick();
    issue_load(3'b010, 2'b00, 5'd12);
    tick(); idle_inputs();
    checks++; if (load_pending !== 1'b1 || writeReg !== 5'd17) begin errors++; $display("FAIL rstw_pre got pend=%0b reg=%0d exp=1/17", load_pending, writeReg); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rd_we !== 1'b0 || err !== 1'b0 || writeReg !== 5'd0 || writeData !== 32'd0) begin errors++; $display("FAIL rstw_async got we=%0b err=%0b %0d/%h exp=0 0 0/0", rd_we, err, writeReg, writeData); end
    checks++; if (load_pending !== 1'b0 || pend_rd !== 5'd0 || ex_ready !== 1'b1) begin errors++; $display("FAIL rstw_state got pend=%0b/%0d rdy=%0b exp=0/0/1", load_pending, pend_rd, ex_ready); end
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    tick(); mem_rvalid = 1'b0;
    checks++; if (rd_we !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rstw_stale got we=%0b err=%0b exp=0/0", rd_we, err); end
  endtask

  task automatic test_random();
    bit          m_wait = 1'b0;
    int          m_left = 0;
    logic [4:0]  m_rd = '0;
    logic [2:0]  m_f3 = '0;
    logic [1:0]  m_lo = '0;
    bit          e_wr, e_err;
    logic [4:0]  e_reg;
    logic [31:0] e_dat;
    for (int c = 0; c < 1500; c++) begin
      ex_valid   = ($urandom_range(0, 1) == 1);
      ex_is_load = ($urandom_range(0, 2) != 0);
      ex_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ex_result  = $urandom;
      ex_funct3  = 3'($urandom);
      ex_addr_lo = 2'($urandom);
      mem_rvalid = ($urandom_range(0, 3) == 0);
      mem_rdata  = $urandom;
      checks++; if (ex_ready !== !m_wait) begin errors++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", c, ex_ready, !m_wait); end
      checks++; if (load_pending !== m_wait || pend_rd !== (m_wait ? m_rd : 5'd0)) begin errors++; $display("FAIL rnd_pend c=%0d got=%0b/%0d exp=%0b/%0d", c, load_pending, pend_rd, m_wait, m_wait ? m_rd : 5'd0); end
      e_wr = 1'b0; e_err = 1'b0; e_reg = '0; e_dat = '0;
      if (!m_wait) begin
        if (ex_valid && !ex_is_load) begin
          e_wr = 1'b1; e_reg = ex_rd; e_dat = ex_result;
        end else if (ex_valid && ref_legal(ex_funct3, ex_addr_lo)) begin
          m_wait = 1'b1; m_left = TO; m_rd = ex_rd; m_f3 = ex_funct3; m_lo = ex_addr_lo;
        end else if (ex_valid) begin
          e_err = 1'b1;
        end
      end else begin
        m_left--;
        if (mem_rvalid) begin
          e_wr = 1'b1; e_reg = m_rd; e_dat = ref_load(m_f3, m_lo, mem_rdata); m_wait = 1'b0;
        end else if (m_left == 0) begin
          e_err = 1'b1; m_wait = 1'b0;
        end
      end
      tick();
      checks++; if (rd_we !== (e_wr && e_reg != 5'd0) || err !== e_err) begin errors++; $display("FAIL rnd_ctl c=%0d got we=%0b err=%0b exp=%0b/%0b", c, rd_we, err, e_wr && e_reg != 5'd0, e_err); end
      if (e_wr) begin
        checks++; if (writeReg !== e_reg || writeData !== e_dat) begin errors++; $display("FAIL rnd_data c=%0d got %0d/%h exp=%0d/%h", c, writeReg, writeData, e_reg, e_dat); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lhu_misalign();
    test_timeout();
    test_rd0();
    test_back_to_back();
    test_reset_wait();
    tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 64, maximum cycles to wait for load data (range 2..255).
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ex_valid  input  1  upstream result/instruction valid.
- ex_ready  output  1  stage can accept; transfer when ex_valid && ex_ready.
- ex_is_load  input  1  instruction is a load.
- ex_rd  input  5  destination register index.
- ex_result  input  32  ALU result, used for non-loads.
- ex_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ex_addr_lo  input  2  load address bits [1:0].
- mem_rvalid  input  1  data-memory read data valid.
- mem_rdata  input  32  data-memory read word, little-endian.
- rd_we  output  1  register-file write enable.
- writeReg  output  5  register-file write index.
- writeData  output  32  register-file write data.
- load_pending  output  1  a load is outstanding.
- pend_rd  output  5  destination of the outstanding load, 0 when none.
- err  output  1  one-cycle error pulse.

Function
REQ-003 SHALL implement FSM states IDLE and WAIT_LOAD; ex_ready = 1 in IDLE only, combinational from state.
REQ-004 SHALL register rd_we, writeReg, writeData, err; all four update every cycle; rd_we and err default to 0 each cycle unless set below.
REQ-005 IDLE, accepted non-load: next cycle rd_we = (ex_rd != 0), writeReg = ex_rd, writeData = ex_result; latency 1 cycle.
REQ-006 IDLE, accepted load with legal funct3 and alignment: capture ex_rd, ex_funct3, ex_addr_lo; go WAIT_LOAD; clear timeout counter.
REQ-007 Alignment: LH/LHU require ex_addr_lo[0] = 0; LW requires ex_addr_lo = 00; LB/LBU always aligned.
REQ-008 Accepted load with illegal funct3 (011, 110, 111) or misalignment: next cycle err = 1, rd_we = 0; stay IDLE.
REQ-009 WAIT_LOAD: load_pending = 1, pend_rd = captured rd; otherwise load_pending = 0, pend_rd = 0.
REQ-010 WAIT_LOAD with mem_rvalid = 1: next cycle rd_we = (captured rd != 0), writeReg = captured rd, writeData = extracted value; return IDLE.
REQ-011 Extraction: byte = mem_rdata[8*addr_lo +: 8]; half = mem_rdata[16*addr_lo[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-012 WAIT_LOAD timeout counter SHALL increment each cycle without mem_rvalid; on reaching TIMEOUT_CYCLES - 1 without mem_rvalid: next cycle err = 1, rd_we = 0, return IDLE.
REQ-013 If mem_rvalid arrives in the same cycle the counter expires, SHALL perform the write (REQ-010) and assert no err.
REQ-014 mem_rvalid in IDLE SHALL be ignored, with no write and no err.
REQ-015 Writes to rd = 0 SHALL never assert rd_we, but writeReg/writeData still update.
REQ-016 Back-to-back: an instruction MAY be accepted in the IDLE cycle immediately following a load completion.

Reset
REQ-017 While rst = 1, asynchronously: state = IDLE; counter = 0; rd_we = 0; writeReg = 0; writeData = 0; err = 0; captured rd/funct3/addr_lo = 0.
REQ-018 Reset asserted in WAIT_LOAD SHALL abandon the load with no write and no err; a mem_rvalid after deassertion is ignored per REQ-014.

Verification
REQ-019 ALU op: ex_valid = 1, ex_is_load = 0, ex_rd = 5, ex_result = 0xDEADBEEF -> next cycle rd_we = 1, writeReg = 5, writeData = 0xDEADBEEF.
REQ-020 LB: funct3 000, addr_lo 11, rd 7; mem_rdata = 0x80FF_1234 after 3 cycles -> ex_ready = 0 and pend_rd = 7 while waiting; then writeData = 0xFFFFFF80, rd_we = 1.
REQ-021 LHU: funct3 101, addr_lo 10, mem_rdata = 0xBEEF_0000 -> writeData = 0x0000BEEF; LH with addr_lo 01 -> err = 1 one cycle, rd_we = 0, state remains IDLE.
REQ-022 Timeout: TIMEOUT_CYCLES = 4, LW, no mem_rvalid -> err = 1 on cycle 4 after acceptance, rd_we = 0, ex_ready = 1 the following cycle; repeat with mem_rvalid on expiry cycle -> write, no err.
REQ-023 rd = 0: ALU op with ex_rd = 0 -> rd_we stays 0.
REQ-024 rd = 0: LW to x0 -> rd_we stays 0.
REQ-025 Reset while WAIT_LOAD -> outputs 0 immediately without clock; subsequent mem_rvalid produces no write.
